// File: rtl/synchronous_ram_param.sv
// Single-port synchronous RAM: byte-lane writes, registered read with rdValid, hardware clear sweep.
// Optional per-lane even parity with a parErr output is enabled by defining SYNCHRONOUS_RAM_PARITY_EN.
module synchronous_ram_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned READ_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CS,
    input  logic                RD,
    input  logic                WE,
    input  logic [DATA_W/8-1:0] BE,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   dataIn,
    input  logic                clear,
    output logic [DATA_W-1:0]   dataOut,
    output logic                rdValid,
`ifdef SYNCHRONOUS_RAM_PARITY_EN
    output logic                ready,
    output logic                parErr
`else
    output logic                ready
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic                ready_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged_word;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rd_word_d;

    // ready_q is only ever high in S_IDLE, so it doubles as the state qualifier here.
    assign accept   = CS && ready_q && !clear;
    assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign idx      = addr[IDX_W-1:0];
    assign old_word = in_range ? mem_q[idx] : '0;

    always_comb begin
        merged_word = old_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (WE && BE[i]) begin
                merged_word[8*i +: 8] = dataIn[8*i +: 8];
            end
        end
    end

    assign wr_en     = (state_q == S_CLEAR) || (accept && WE && in_range && (|BE));
    assign wr_idx    = (state_q == S_CLEAR) ? clr_addr_q[IDX_W-1:0] : idx;
    assign wr_word   = (state_q == S_CLEAR) ? '0 : merged_word;
    assign rd_word_d = !in_range ? '0 : ((READ_MODE != 0) ? merged_word : old_word);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

`ifdef SYNCHRONOUS_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] old_par;
    logic [NB-1:0] merged_par;
    logic [NB-1:0] rd_par;
    logic [NB-1:0] rd_calc;
    logic          par_err_q;
    logic          par_err_d;

    assign old_par = in_range ? par_q[idx] : '0;

    always_comb begin
        merged_par = old_par;
        rd_calc    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (WE && BE[i]) begin
                merged_par[i] = ^dataIn[8*i +: 8];
            end
            rd_calc[i] = ^rd_word_d[8*i +: 8];
        end
    end

    assign rd_par    = !in_range ? '0 : ((READ_MODE != 0) ? merged_par : old_par);
    assign par_err_d = |(rd_par ^ rd_calc);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_q[wr_idx] <= (state_q == S_CLEAR) ? '0 : merged_par;
        end
    end

    assign parErr = par_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
`ifdef SYNCHRONOUS_RAM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
`ifdef SYNCHRONOUS_RAM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
            unique case (state_q)
                S_CLEAR: begin
                    if (clear) begin
                        clr_addr_q <= '0;
                    end else if (clr_addr_q == LAST_ADDR) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (clear) begin
                        state_q    <= S_CLEAR;
                        clr_addr_q <= '0;
                        ready_q    <= 1'b0;
                    end else if (accept && RD) begin
                        data_out_q <= rd_word_d;
                        rd_valid_q <= 1'b1;
`ifdef SYNCHRONOUS_RAM_PARITY_EN
                        par_err_q  <= par_err_d;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign dataOut = data_out_q;
    assign rdValid = rd_valid_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_synchronous_ram_param.sv
// Scoreboard bench: two RAM instances (DEPTH=8 read-first, DEPTH=6 write-first) driven by shared stimulus.
module tb_synchronous_ram_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        CS = 1'b0, RD = 1'b0, WE = 1'b0, clear = 1'b0;
    logic [1:0]  BE = '0;
    logic [2:0]  addr = '0;
    logic [15:0] dataIn = '0;
    logic [15:0] dout_a, dout_b;
    logic        rv_a, rv_b, rdy_a, rdy_b;
`ifdef SYNCHRONOUS_RAM_PARITY_EN
    logic        perr_a, perr_b;
`endif

    always #5 clk = ~clk;

    synchronous_ram_param #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .READ_MODE(0)) dut (
        .clk(clk), .reset(reset), .CS(CS), .RD(RD), .WE(WE), .BE(BE), .addr(addr),
        .dataIn(dataIn), .clear(clear), .dataOut(dout_a), .rdValid(rv_a), .ready(rdy_a)
`ifdef SYNCHRONOUS_RAM_PARITY_EN
        , .parErr(perr_a)
`endif
    );

    synchronous_ram_param #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .READ_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .CS(CS), .RD(RD), .WE(WE), .BE(BE), .addr(addr),
        .dataIn(dataIn), .clear(clear), .dataOut(dout_b), .rdValid(rv_b), .ready(rdy_b)
`ifdef SYNCHRONOUS_RAM_PARITY_EN
        , .parErr(perr_b)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic        perr;
        int unsigned cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    bit          par_flip = 1'b0;

    // Reference model: word array per instance plus remaining clear-sweep cycles.
    logic [15:0] mem_m [2][8];
    logic [15:0] last_m [2];
    int unsigned clr_left [2];
    int unsigned depth_m [2] = '{8, 6};
    bit          rmode_m [2] = '{1'b0, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = depth_m[k];
            last_m[k]   = '0;
            for (int i = 0; i < 8; i++) mem_m[k][i] = '0;
        end
    endtask

    task automatic model_edge(input int k);
        logic [15:0] old_w, new_w;
        bit          inr;
        exp_t        e;
        if (clr_left[k] > 0) begin
            if (clear) clr_left[k] = depth_m[k];
            else       clr_left[k]--;
        end else if (clear) begin
            clr_left[k] = depth_m[k];
            for (int i = 0; i < 8; i++) mem_m[k][i] = '0;
        end else if (CS) begin
            inr   = (int'(addr) < int'(depth_m[k]));
            old_w = inr ? mem_m[k][addr] : 16'h0000;
            new_w = old_w;
            for (int i = 0; i < 2; i++)
                if (WE && BE[i]) new_w[8*i +: 8] = dataIn[8*i +: 8];
            if (WE && inr) mem_m[k][addr] = new_w;
            if (RD) begin
                e.data = !inr ? 16'h0000 : (rmode_m[k] ? new_w : old_w);
                e.perr = (k == 0) && par_flip && (addr == 3'd4);
                e.cyc  = cyc + 1;
                if (k == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
        end
    endtask

    // Inputs are applied at a negedge; tasks start and end at a negedge.
    task automatic step(input bit cs, input bit rd, input bit we, input logic [1:0] be,
                        input logic [2:0] a, input logic [15:0] d, input bit clr);
        CS = cs; RD = rd; WE = we; BE = be; addr = a; dataIn = d; clear = clr;
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check("ready_a", {31'd0, rdy_a}, {31'd0, clr_left[0] == 0});
        check("ready_b", {31'd0, rdy_b}, {31'd0, clr_left[1] == 0});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        step(1'b1, 1'b0, 1'b1, be, a, d, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b1, 1'b0, 2'b00, a, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        CS = 1'b0; RD = 1'b0; WE = 1'b0; clear = 1'b0; BE = '0;
        model_reset();
        #1;
        check("rst_ready_a", {31'd0, rdy_a}, 32'd0);
        check("rst_valid_a", {31'd0, rv_a}, 32'd0);
        check("rst_dout_a", {16'd0, dout_a}, 32'd0);
        check("rst_ready_b", {31'd0, rdy_b}, 32'd0);
        check("rst_dout_b", {16'd0, dout_b}, 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic mon(input int k, input logic rv, input logic [15:0] d, input logic pe);
        exp_t e;
        int unsigned qs;
        qs = (k == 0) ? q_a.size() : q_b.size();
        if (rv === 1'b1) begin
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL rdValid_%0d actual=1 expected=0 (t=%0t)", k, $time);
            end else begin
                if (k == 0) e = q_a.pop_front();
                else        e = q_b.pop_front();
                check($sformatf("rd_latency_%0d", k), cyc, e.cyc);
                check($sformatf("dataOut_%0d", k), {16'd0, d}, {16'd0, e.data});
`ifdef SYNCHRONOUS_RAM_PARITY_EN
                check($sformatf("parErr_%0d", k), {31'd0, pe}, {31'd0, e.perr});
`endif
                last_m[k] = e.data;
            end
        end else begin
            check($sformatf("dataOut_hold_%0d", k), {16'd0, d}, {16'd0, last_m[k]});
            if (qs != 0) begin
                if (k == 0) e = q_a[0];
                else        e = q_b[0];
                if (e.cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rdValid_%0d actual=0 expected=1 (t=%0t)", k, $time);
                    if (k == 0) void'(q_a.pop_front());
                    else        void'(q_b.pop_front());
                end
            end
        end
`ifndef SYNCHRONOUS_RAM_PARITY_EN
        if (pe) $display("unexpected parity input");
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
`ifdef SYNCHRONOUS_RAM_PARITY_EN
            mon(0, rv_a, dout_a, perr_a);
            mon(1, rv_b, dout_b, perr_b);
`else
            mon(0, rv_a, dout_a, 1'b0);
            mon(1, rv_b, dout_b, 1'b0);
`endif
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Reads held during the sweep must be ignored until ready.
        repeat (8) step(1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) rd(3'(i));

        wr(3'd5, 16'hA5C3, 2'b11);
        wr(3'd5, 16'hFFFF, 2'b01);
        rd(3'd5);
        idle();

        wr(3'd2, 16'h1234, 2'b11);
        step(1'b1, 1'b1, 1'b1, 2'b11, 3'd2, 16'hBEEF, 1'b0);
        rd(3'd2);
        wr(3'd3, 16'hDEAD, 2'b00);
        rd(3'd3);

        wr(3'd6, 16'h7777, 2'b11);
        rd(3'd6);
        rd(3'd7);
        for (int i = 0; i < 6; i++) rd(3'(i));

        for (int i = 0; i < 8; i++) wr(3'(i), 16'h5A5A, 2'b11);
        step(1'b1, 1'b0, 1'b1, 2'b11, 3'd1, 16'h1111, 1'b1);
        repeat (8) idle();
        for (int i = 0; i < 8; i++) rd(3'(i));

        for (int i = 0; i < 8; i++) wr(3'(i), 16'h5A5A, 2'b11);
        step(1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
        repeat (3) idle();
        do_reset();
        repeat (8) idle();
        for (int i = 0; i < 8; i++) rd(3'(i));

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 49) == 0);
        end
        repeat (10) idle();
        for (int i = 0; i < 8; i++) rd(3'(i));

`ifdef SYNCHRONOUS_RAM_PARITY_EN
        wr(3'd4, 16'h0103, 2'b11);
        idle();
        dut.par_q[4][0] = ~dut.par_q[4][0];
        par_flip = 1'b1;
        rd(3'd4);
        rd(3'd3);
        rd(3'd5);
`endif

        repeat (3) idle();
        check("queue_a_drained", q_a.size(), 32'd0);
        check("queue_b_drained", q_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/synchronous_ram_param.md
Name: synchronous_ram_param

Overview:
- Parametrised single-port synchronous RAM; next generation of the team's small fixed 4x8 RAM.
- Adds:
  - configurable width and depth
  - per-byte write enables
  - registered read with a valid strobe
  - selectable read-during-write mode
  - hardware clear sequencer, so contents are defined after reset without a software sweep
- Sits on the local register/data bus behind the chip-select decode.

Parameters:
- DATA_W, 16: data width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- ADDR_W, 3: address width.
- DEPTH, 8: number of words; 1 <= DEPTH <= 2**ADDR_W.
- READ_MODE, 0: same-address read and write in one cycle. 0 = read-first (old data), 1 = write-first (new merged data).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- CS  input  1  chip select; RD and WE are ignored when low.
- RD  input  1  read request.
- WE  input  1  write request.
- BE  input  NB  byte-lane write enables; BE[i] covers dataIn[8i+7:8i].
- addr  input  ADDR_W  word address.
- dataIn  input  DATA_W  write data.
- clear  input  1  synchronous request to re-zero the whole array.
- dataOut  output  DATA_W  registered read data.
- rdValid  output  1  one-cycle pulse; dataOut is updated this cycle.
- ready  output  1  high when the block accepts accesses (IDLE state).

Behaviour:
- Reset (async assert):
  - dataOut=0, rdValid=0, ready=0.
  - State CLEAR, clear address clrAddr=0.
  - Array is not reset asynchronously.
- FSM states:
  - CLEAR:
    - Each posedge writes 0 to mem[clrAddr].
    - If clrAddr==DEPTH-1: go to IDLE and set ready=1. Otherwise clrAddr++.
    - ready rises after exactly DEPTH posedges following reset release.
  - IDLE:
    - clear=1 at a posedge: go to CLEAR, clrAddr=0, ready=0. Any RD/WE in that cycle is dropped.
- Clear sequencer rules:
  - clear=1 while already in CLEAR restarts the sweep at clrAddr=0.
  - Reset asserted mid-sweep restarts the sweep from 0 after release.
- Accepted access: CS & ready & !clear at a posedge. RD and WE with CS low, or while ready=0, are ignored. No rdValid is produced for them.
- Write:
  - For each i with BE[i]=1, byte i of mem[addr] is replaced by byte i of dataIn. Other bytes are retained.
  - WE with BE=0 is a no-op.
- Read:
  - 1-cycle latency: RD accepted at edge N, so dataOut is valid and rdValid=1 after edge N.
  - rdValid is low after edge N+1 unless another RD is accepted.
  - dataOut holds its last value when no read is accepted.
- RD and WE together, same cycle:
  - Write is performed.
  - Read returns the pre-write word (READ_MODE=0) or the post-merge word (READ_MODE=1).
- Out of range (addr >= DEPTH):
  - Write dropped.
  - Read returns all-zeros, with rdValid=1.
- Back-to-back accesses are allowed every cycle; no stall is needed in IDLE.

Optional Feature:
- Macro: SYNCHRONOUS_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane. It is written with its lane and cleared to 0 by the sweep.
  - Output port parErr (1 bit) pulses together with rdValid when any read lane's stored parity mismatches the recomputed parity.
  - parErr resets to 0.
  - Parity bits have no other effect on dataOut.
- Not defined: no parity storage and no parErr port. Behaviour is otherwise identical.

Test Plan (DATA_W=16, ADDR_W=3, DEPTH=8 unless stated):
1. Release reset, hold CS=1, RD=1, addr=0 -> ready=0 and rdValid=0 for 8 posedges; ready=1 after the 8th. The first accepted read of every address 0..7 gives dataOut=0x0000.
2. Write addr=5, dataIn=0xA5C3, BE=2'b11; then write dataIn=0xFFFF, BE=2'b01; then RD addr=5 -> dataOut=0xA5FF with rdValid=1 exactly one cycle after the RD edge.
3. Same-cycle RD+WE at addr=2, old value 0x1234, new 0xBEEF, BE=11 -> READ_MODE=0 gives dataOut=0x1234; READ_MODE=1 gives dataOut=0xBEEF. A following read gives 0xBEEF in both modes.
4. DEPTH=6: write 0x7777 to addr=6, then read addr=6 and addr=7 -> 0x0000 with rdValid=1. Addresses 0..5 are unchanged.
5. Fill all addresses with 0x5A5A; pulse clear together with WE to addr=1 -> ready=0 for 8 cycles; the write is dropped; all words read back 0x0000. Assert reset at sweep step 3 -> ready reasserts 8 posedges after release.
6. With SYNCHRONOUS_RAM_PARITY_EN: write 0x0103 to addr=4, force the stored parity bit of lane 0 to flip via hierarchical deposit, RD addr=4 -> dataOut=0x0103, rdValid=1 and parErr=1 in the same cycle. Reading other addresses gives parErr=0.
